fractal_sync_tx: RTL and testbench

FRACTAL_SYNC_TX -- requirements
Module: fractal_sync_tx

---
 rtl/fractal_sync_pkg.sv | 23 ++
 rtl/fractal_if.sv | 34 +++
 rtl/fractal_sync_tx.sv | 151 +++++++++++++++
 tb/tb_fractal_sync_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// ============================================================================
// fractal_sync_pkg
// Shared FSM state encoding and default widths for the fractal sync blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fractal_sync_pkg;

    localparam int unsigned DEFAULT_AGGR_WIDTH = 1;
    localparam int unsigned DEFAULT_ID_WIDTH   = 1;
    localparam int unsigned DEFAULT_SD_WIDTH   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fractal_if.sv
// ============================================================================
// fractal_if
// Synchronization link between a requester and a fractal sync tree node.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fractal_if #(
    parameter int unsigned AGGR_WIDTH = fractal_sync_pkg::DEFAULT_AGGR_WIDTH,
    parameter int unsigned ID_WIDTH   = fractal_sync_pkg::DEFAULT_ID_WIDTH,
    parameter int unsigned SD_WIDTH   = fractal_sync_pkg::DEFAULT_SD_WIDTH
) ();

    logic                  sync;
    logic [AGGR_WIDTH-1:0] aggr;
    logic [ID_WIDTH-1:0]   id;
    logic [SD_WIDTH-1:0]   src;
    logic                  wake;
    logic [SD_WIDTH-1:0]   dst;
    logic                  error;

    modport mst_port (
        output sync, aggr, id, src,
        input  wake, dst, error
    );

    modport slv_port (
        input  sync, aggr, id, src,
        output wake, dst, error
    );

endinterface

`default_nettype wire

// File: rtl/fractal_sync_tx.sv
// ============================================================================
// fractal_sync_tx
// Core-side barrier requester: issues one sync pulse upstream, waits for a
// matching wake (or error) and returns a completion to the core.
// Optional wake watchdog: define FRACTAL_SYNC_TX_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fractal_sync_tx
    import fractal_sync_pkg::*;
#(
    parameter int unsigned        AGGR_WIDTH     = DEFAULT_AGGR_WIDTH,
    parameter int unsigned        ID_WIDTH       = DEFAULT_ID_WIDTH,
    parameter int unsigned        SD_WIDTH       = DEFAULT_SD_WIDTH,
    parameter logic [SD_WIDTH-1:0] SRC_MASK      = 'b01,
    parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AGGR_WIDTH-1:0] req_aggr_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_error_o,
    output logic                  spurious_o,
    fractal_if.mst_port           sync_mst
);

    if ($countones(SRC_MASK) != 1) begin : g_src_mask_check
        $error("SRC_MASK must have exactly one bit set");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                r_state;
    state_e                w_state_next;
    logic [AGGR_WIDTH-1:0] r_aggr;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_err;
    logic                  r_spurious;
    logic                  w_wake_match;
    logic                  w_wd_expired;
    logic                  w_sync;
    logic [AGGR_WIDTH-1:0] w_aggr;
    logic [ID_WIDTH-1:0]   w_id;
    logic [SD_WIDTH-1:0]   w_src;

    assign w_wake_match = sync_mst.wake && ((sync_mst.dst & SRC_MASK) != '0);

`ifdef FRACTAL_SYNC_TX_TIMEOUT_EN
    localparam int unsigned c_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_WIDTH-1:0] r_wd_cnt;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != ST_WAIT)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_expired = (r_wd_cnt == c_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign w_wd_expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_aggr     <= '0;
            r_id       <= '0;
            r_err      <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_spurious <= w_wake_match && (r_state != ST_WAIT);
            if ((r_state == ST_IDLE) && req_valid_i) begin
                r_aggr <= req_aggr_i;
                r_id   <= req_id_i;
            end
            // A matching wake wins over error-only and watchdog exits.
            if ((r_state == ST_WAIT) && (w_state_next == ST_RESP)) begin
                r_err <= w_wake_match ? sync_mst.error : 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid_i) w_state_next = ST_SYNC;
            ST_SYNC: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_wake_match || sync_mst.error || w_wd_expired) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: if (resp_ready_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of state.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_error_o = 1'b0;
        spurious_o   = 1'b0;
        w_sync       = 1'b0;
        w_aggr       = '0;
        w_id         = '0;
        w_src        = '0;
        if (!rst_i) begin
            spurious_o = r_spurious;
            case (r_state)
                ST_IDLE: req_ready_o = 1'b1;
                ST_SYNC: begin
                    w_sync = 1'b1;
                    w_aggr = r_aggr;
                    w_id   = r_id;
                    w_src  = SRC_MASK;
                end
                ST_RESP: begin
                    resp_valid_o = 1'b1;
                    resp_error_o = r_err;
                end
                default: ;
            endcase
        end
    end

    assign sync_mst.sync = w_sync;
    assign sync_mst.aggr = w_aggr;
    assign sync_mst.id   = w_id;
    assign sync_mst.src  = w_src;

endmodule

`default_nettype wire

// File: tb/tb_fractal_sync_tx.sv
// ============================================================================
// tb_fractal_sync_tx
// Randomized transaction-level bench for fractal_sync_tx.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fractal_sync_tx;

    localparam int unsigned AW  = 2;
    localparam int unsigned IW  = 2;
    localparam int unsigned SW  = 2;
    localparam logic [1:0]  SRC = 2'b01;
    localparam int unsigned TO  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_aggr;
    logic [IW-1:0] req_id;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_error;
    logic          spurious;

    int n_checks = 0;
    int n_errors = 0;

    fractal_if #(.AGGR_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(SW)) u_if ();

    fractal_sync_tx #(
        .AGGR_WIDTH    (AW),
        .ID_WIDTH      (IW),
        .SD_WIDTH      (SW),
        .SRC_MASK      (SRC),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_aggr_i  (req_aggr),
        .req_id_i    (req_id),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_error_o(resp_error),
        .spurious_o  (spurious),
        .sync_mst    (u_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_wake();
        u_if.wake  = 1'b0;
        u_if.dst   = '0;
        u_if.error = 1'b0;
    endtask

    // Advance one clock; a matching wake seen outside WAIT must pulse spurious.
    task automatic tick(input bit in_wait);
        logic exp_sp;
        exp_sp = u_if.wake && ((u_if.dst & SRC) != 2'b00) && !in_wait && !rst;
        @(posedge clk);
        #1;
        check("spurious", 32'(spurious), 32'(exp_sp));
    endtask

    task automatic expect_outs(input string tag, input bit ready, input bit sync,
                               input logic [1:0] aggr, input logic [1:0] id,
                               input bit rv, input bit re);
        check({tag, ".req_ready"},  32'(req_ready),  32'(ready));
        check({tag, ".sync"},       32'(u_if.sync),  32'(sync));
        check({tag, ".aggr"},       32'(u_if.aggr),  32'(sync ? aggr : 2'b00));
        check({tag, ".id"},         32'(u_if.id),    32'(sync ? id : 2'b00));
        check({tag, ".src"},        32'(u_if.src),   32'(sync ? SRC : 2'b00));
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'(rv));
        check({tag, ".resp_error"}, 32'(resp_error), 32'(re));
    endtask

    // Issue a request and step the bench to the start of the WAIT phase.
    task automatic issue_req(input logic [1:0] a, input logic [1:0] i, input bit sync_wake);
        req_valid = 1'b1;
        req_aggr  = a;
        req_id    = i;
        check("req.ready_pre", 32'(req_ready), 32'd1);
        tick(0);
        req_valid = 1'b0;
        req_aggr  = AW'($urandom);
        req_id    = IW'($urandom);
        expect_outs("sync", 0, 1, a, i, 0, 0);
        u_if.wake = sync_wake;
        u_if.dst  = SRC;
        tick(0);
        clear_wake();
        expect_outs("wait_entry", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic finish_resp(input bit exp_err, input int hold);
        repeat (hold) begin
            u_if.wake  = 1'($urandom_range(0, 1));
            u_if.dst   = SRC;
            u_if.error = 1'($urandom);
            req_valid  = 1'($urandom);
            tick(0);
            clear_wake();
            req_valid = 1'b0;
            expect_outs("resp_hold", 0, 0, 0, 0, 1, exp_err);
        end
        // A request presented with the handshake must not be taken.
        resp_ready = 1'b1;
        req_valid  = 1'($urandom_range(0, 1));
        tick(0);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        expect_outs("after_resp", 1, 0, 0, 0, 0, 0);
    endtask

    // kind: 0 = clean wake, 1 = wake carrying error, 2 = error without wake
    task automatic run_txn(input logic [1:0] a, input logic [1:0] i, input int kind,
                           input int wait_len, input int hold);
        bit exp_err;
        repeat ($urandom_range(0, 2)) begin
            u_if.wake  = 1'($urandom);
            u_if.dst   = SW'($urandom);
            u_if.error = 1'($urandom);
            tick(0);
            clear_wake();
            expect_outs("idle_noise", 1, 0, 0, 0, 0, 0);
        end
        issue_req(a, i, 1'($urandom_range(0, 1)));
        repeat (wait_len) begin
            if ($urandom_range(0, 1) == 1) begin
                u_if.wake = 1'b1;
                u_if.dst  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            end
            tick(1);
            clear_wake();
            expect_outs("wait", 0, 0, 0, 0, 0, 0);
        end
        case (kind)
            0: begin
                u_if.wake = 1'b1;
                u_if.dst  = ($urandom_range(0, 1) == 1) ? 2'b11 : SRC;
                exp_err   = 1'b0;
            end
            1: begin
                u_if.wake  = 1'b1;
                u_if.dst   = SRC;
                u_if.error = 1'b1;
                exp_err    = 1'b1;
            end
            default: begin
                u_if.wake  = 1'($urandom);
                u_if.dst   = 2'b10;
                u_if.error = 1'b1;
                exp_err    = 1'b1;
            end
        endcase
        tick(1);
        clear_wake();
        expect_outs("resp", 0, 0, 0, 0, 1, exp_err);
        finish_resp(exp_err, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int max_wait;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_aggr   = 2'b11;
        req_id     = 2'b11;
        resp_ready = 1'b1;
        u_if.wake  = 1'b1;
        u_if.dst   = SRC;
        u_if.error = 1'b1;
        repeat (3) tick(0);
        expect_outs("reset", 0, 0, 0, 0, 0, 0);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        clear_wake();
        rst = 1'b0;
        tick(0);
        expect_outs("post_reset", 1, 0, 0, 0, 0, 0);

        // Directed: aggr=01 id=3, matching wake a few cycles into WAIT.
        run_txn(2'b01, 2'b11, 0, 4, 0);
        // Directed: error-only completion held unacknowledged for 10 cycles.
        run_txn(2'b10, 2'b01, 2, 2, 10);

`ifdef FRACTAL_SYNC_TX_TIMEOUT_EN
        max_wait = 5;
`else
        max_wait = 12;
`endif
        repeat (30) begin
            run_txn(2'($urandom), 2'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, max_wait), $urandom_range(0, 4));
        end

        // Reset in the middle of WAIT, then a matching wake lands in IDLE.
        issue_req(2'b11, 2'b10, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(1);
        expect_outs("mid_wait_reset", 0, 0, 0, 0, 0, 0);
        rst       = 1'b0;
        u_if.wake = 1'b1;
        u_if.dst  = SRC;
        tick(0);
        clear_wake();
        expect_outs("wake_after_reset", 1, 0, 0, 0, 0, 0);
        tick(0);
        expect_outs("idle_after_reset", 1, 0, 0, 0, 0, 0);

`ifdef FRACTAL_SYNC_TX_TIMEOUT_EN
        // Watchdog expiry after TO WAIT cycles; a wake on the last cycle wins.
        for (int v = 0; v < 2; v++) begin
            issue_req(2'b01, 2'b01, 1'b0);
            for (int k = 1; k < TO; k++) begin
                tick(1);
                expect_outs("wd_wait", 0, 0, 0, 0, 0, 0);
            end
            if (v == 1) begin
                u_if.wake = 1'b1;
                u_if.dst  = SRC;
            end
            tick(1);
            clear_wake();
            expect_outs("wd_resp", 0, 0, 0, 0, 1, (v == 0));
            finish_resp((v == 0), 1);
        end
`else
        // Without the watchdog, WAIT persists well past TIMEOUT_CYCLES.
        issue_req(2'b10, 2'b11, 1'b0);
        repeat (4 * TO) begin
            tick(1);
            expect_outs("long_wait", 0, 0, 0, 0, 0, 0);
        end
        u_if.wake = 1'b1;
        u_if.dst  = SRC;
        tick(1);
        clear_wake();
        expect_outs("long_resp", 0, 0, 0, 0, 1, 0);
        finish_resp(1'b0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
